fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC and is the Wishbone-classic read master on the instruction port.
//  Delivers {pc, instruction, exception} to ifid_register via a valid/ready handshake.
//  Accepts redirects (branch/jump/trap targets) from later stages, and kills any in-flight fetch.
//  One outstanding bus request at a time. Replaces the pc_reg/pc_add/load_store_unit fetch path.
// PARAMETERS
//  RESET_ADDR   32'h0000_0000   PC loaded on reset; must be 4-byte aligned
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst            in   1   reset: synchronous, active-high
//  redirect_i     in   1   1-cycle pulse: load new PC, flush stage
//  redirect_pc_i  in   32  redirect target
//  inst_valid_o   out  1   pc_o/inst_o/exc_o hold a valid fetch result
//  inst_ready_i   in   1   downstream accepts the result this cycle
//  pc_o           out  32  address of inst_o
//  inst_o         out  32  fetched instruction; NOP 32'h0000_0013 when exc_o != 0
//  exc_o          out  2   00 none, 01 bus error, 10 misaligned PC
//  iaddr_o        out  32  Wishbone address (= fetch PC)
//  idat_o         out  32  constant 0
//  isel_o         out  4   constant 4'hF
//  icyc_o         out  1   Wishbone cycle
//  istb_o         out  1   Wishbone strobe (== icyc_o)
//  iwe_o          out  1   constant 0
//  idat_i         in   32  Wishbone read data
//  iack_i         in   1   Wishbone acknowledge
//  ierr_i         in   1   Wishbone error
// BEHAVIOUR
//  - Reset: pc_q = RESET_ADDR, state IDLE, kill = 0, icyc/istb = 0, inst_valid_o = 0, pc_o = 0,
//    inst_o = NOP, exc_o = 00. Reset mid-transaction drops cyc/stb at that edge; late ack/err ignored.
//  - States: IDLE, REQ, HALT.
//  - IDLE:
//    - Go to REQ when (!inst_valid_o || inst_ready_i) && !redirect_i.
//    - If pc_q[1:0] != 0: load the output register with exc = 10, inst = NOP, pc = pc_q; go to HALT.
//    - No bus request is made in this case.
//  - REQ: icyc_o = istb_o = 1, iaddr_o = pc_q, held stable until iack_i or ierr_i.
//    - ierr_i (wins over a simultaneous iack_i), kill = 0: load output with exc = 01, inst = NOP,
//      pc = pc_q; go to HALT.
//    - iack_i, kill = 0: load output with idat_i, pc_q, exc = 00; pc_q += 4 (wraps
//      32'hFFFF_FFFC -> 0, no fault); go to IDLE.
//    - iack_i or ierr_i with kill = 1: discard the response, clear kill, go to IDLE.
//  - Output register is only loaded from REQ or IDLE, which are entered only when the register
//    is free, so an ack is never dropped. Latency: ack-to-inst_valid_o is 1 cycle.
//    Peak throughput is 1 instruction per (bus latency + 1) cycles.
//  - Handshake: pc_o/inst_o/exc_o stable while inst_valid_o && !inst_ready_i.
//    The result transfers on inst_valid_o && inst_ready_i. inst_ready_i while invalid is ignored.
//  - HALT: no bus activity; the result stays offered until consumed. Left only via redirect_i or rst.
//  - redirect_i (highest priority after rst), same edge:
//    - pc_q = redirect_pc_i; inst_valid_o = 0 (flush, even if being consumed).
//    - In REQ without a response this cycle: set kill and stay in REQ.
//    - In REQ with a response this cycle: discard it, go to IDLE.
//    - In IDLE/HALT: go to IDLE.
//    - A back-to-back redirect only updates pc_q again.
// STRUCTURE
//  - Shared defines header: state encodings, NOP constant, EXC_NONE/EXC_BUS/EXC_MISALIGN, default RESET_ADDR.
//  - One sub-module: fetch_buffer, a 1-entry valid/ready output register (load, flush, consume)
//    holding pc/inst/exc.
//  - FSM, PC and kill flag stay in fetch_unit.
// TESTING
//  1. Reset, bram with 1-cycle ack, ready = 1 -> first request iaddr 0x0, pc_o sequence 0x0, 0x4, 0x8
//     with matching words; bus stays idle until the reset-plus-IDLE cycle completes.
//  2. Hold inst_ready_i = 0 for 5 cycles after pc_o = 0x4 valid -> outputs stable, icyc_o = 0
//     during the stall; on release the next iaddr is 0x8.
//  3. Ack delayed 3 cycles; redirect_i to 0x100 in the 2nd wait cycle -> the stale word is never
//     valid; the next request is iaddr 0x100 after the ack; the first valid pc_o is 0x100.
//  4. ierr_i and iack_i together at iaddr 0x20 -> inst_valid_o, pc_o = 0x20, inst_o = 0x00000013,
//     exc_o = 01; no further cyc until redirect to 0x40 resumes fetching at 0x40.
//  5. Redirect to 0x102 -> no bus cycle; pc_o = 0x102, exc_o = 10, then HALT.
//     Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0.
//  6. rst asserted while icyc_o = 1 -> icyc_o = 0 next cycle; a late iack_i produces no valid
//     output; the next fetch is RESET_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 2;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0]  NOP_INST           = 32'h0000_0013;
  localparam logic [XLEN-1:0]  DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [EXC_W-1:0] EXC_NONE           = 2'b00;
  localparam logic [EXC_W-1:0] EXC_BUS            = 2'b01;
  localparam logic [EXC_W-1:0] EXC_MISALIGN       = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [EXC_W-1:0] exc;
  } fetch_result_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage signal bundle: redirect input, downstream handshake and Wishbone read port.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             inst_valid_o;
  logic             inst_ready_i;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  inst_o;
  logic [EXC_W-1:0] exc_o;
  logic [XLEN-1:0]  iaddr_o;
  logic [XLEN-1:0]  idat_o;
  logic [SEL_W-1:0] isel_o;
  logic             icyc_o;
  logic             istb_o;
  logic             iwe_o;
  logic [XLEN-1:0]  idat_i;
  logic             iack_i;
  logic             ierr_i;

  modport master (
    input  redirect_i, redirect_pc_i, inst_ready_i, idat_i, iack_i, ierr_i,
    output inst_valid_o, pc_o, inst_o, exc_o, iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, inst_ready_i, idat_i, iack_i, ierr_i,
    input  inst_valid_o, pc_o, inst_o, exc_o, iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry valid/ready output register holding a fetch result.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic          consume,
  input  fetch_result_t din,
  output logic          valid,
  output fetch_result_t dout
);

  // Flush beats load, load beats consume: a new result may replace one leaving this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '{pc: '0, inst: NOP_INST, exc: EXC_NONE};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner and single-outstanding Wishbone-classic read master.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q;
  logic            kill_q, kill_d;
  logic            cyc_q;
  logic            buf_load, buf_flush, buf_valid;
  fetch_result_t   buf_din, buf_q;
  logic            resp, buf_free;

  assign resp     = bus.iack_i | bus.ierr_i;
  assign buf_free = !buf_valid || bus.inst_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      kill_q  <= 1'b0;
      cyc_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      cyc_q   <= (state_d == ST_REQ);
      // Latch the bus address at request start so a killed request keeps a stable address.
      if (state_d == ST_REQ && state_q != ST_REQ) addr_q <= pc_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    buf_din   = '{pc: pc_q, inst: NOP_INST, exc: EXC_NONE};

    if (bus.redirect_i) begin
      pc_d      = bus.redirect_pc_i;
      buf_flush = 1'b1;
      // An unanswered request must still complete on the bus; remember to drop its data.
      if (state_q == ST_REQ && !resp) begin
        kill_d = 1'b1;
      end else begin
        kill_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (buf_free) begin
            if (pc_q[1:0] != 2'b00) begin
              buf_load    = 1'b1;
              buf_din.exc = EXC_MISALIGN;
              state_d     = ST_HALT;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (resp) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (bus.ierr_i) begin
              buf_load    = 1'b1;
              buf_din.exc = EXC_BUS;
              state_d     = ST_HALT;
            end else begin
              buf_load     = 1'b1;
              buf_din.inst = bus.idat_i;
              pc_d         = pc_q + 32'd4;
              state_d      = ST_IDLE;
            end
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .flush   (buf_flush),
    .consume (bus.inst_ready_i),
    .din     (buf_din),
    .valid   (buf_valid),
    .dout    (buf_q)
  );

  assign bus.inst_valid_o = buf_valid;
  assign bus.pc_o         = buf_q.pc;
  assign bus.inst_o       = buf_q.inst;
  assign bus.exc_o        = buf_q.exc;
  assign bus.iaddr_o      = addr_q;
  assign bus.idat_o       = '0;
  assign bus.isel_o       = 4'hF;
  assign bus.icyc_o       = cyc_q;
  assign bus.istb_o       = cyc_q;
  assign bus.iwe_o        = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirects, stalls, bus errors and reset against a memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned BUDGET = 200;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  fetch_result_t   exp_q[$];
  logic [31:0]     req_log[$];

  int          latency  = 0;
  logic [31:0] err_addr = 32'h0000_0001;
  logic        late_ack = 1'b0;
  int          wait_cnt = 0;
  logic        prev_cyc = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_xfers(input int target, input string name);
    int k;
    k = 0;
    while (xfer_cnt < target && k < BUDGET) begin
      tick(1);
      k++;
    end
    if (xfer_cnt < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d transfers, required %0d", name, xfer_cnt, target);
    end
  endtask

  task automatic check_log(input int idx, input logic [31:0] addr, input string name);
    if (idx < req_log.size()) begin
      check(name, req_log[idx], addr);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d requests, required entry %0d = %h", name, req_log.size(), idx, addr);
    end
  endtask

  // Wishbone slave: ack after `latency` wait cycles, error at err_addr (asserted with ack).
  always @(negedge clk) begin
    if (late_ack) begin
      bus.iack_i = 1'b1;
      bus.ierr_i = 1'b0;
      bus.idat_i = 32'hBAD0_BAD0;
    end else if (bus.icyc_o && !rst) begin
      if (wait_cnt >= latency) begin
        bus.iack_i = 1'b1;
        bus.ierr_i = (bus.iaddr_o == err_addr);
        bus.idat_i = mem_word(bus.iaddr_o);
        wait_cnt   = 0;
      end else begin
        bus.iack_i = 1'b0;
        bus.ierr_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.iack_i = 1'b0;
      bus.ierr_i = 1'b0;
      bus.idat_i = 32'h0;
      wait_cnt   = 0;
    end
  end

  // Request logger: records each new bus cycle and checks address stability within it.
  always @(negedge clk) begin
    if (!rst && bus.icyc_o) begin
      if (!prev_cyc) begin
        req_log.push_back(bus.iaddr_o);
        check("wb_static", {bus.istb_o, bus.iwe_o, bus.isel_o, bus.idat_o[25:0]},
              {1'b1, 1'b0, 4'hF, 26'h0});
      end else if (req_log.size() > 0) begin
        check("iaddr_stable", bus.iaddr_o, req_log[req_log.size()-1]);
      end
    end
    prev_cyc = bus.icyc_o && !rst;
  end

  // Scoreboard monitor: every transfer pops one expected result.
  always @(negedge clk) begin
    fetch_result_t e;
    if (!rst && bus.inst_valid_o && bus.inst_ready_i) begin
      xfer_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got pc=%h inst=%h exc=%b, required no result",
                 bus.pc_o, bus.inst_o, bus.exc_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.pc_o !== e.pc || bus.inst_o !== e.inst || bus.exc_o !== e.exc) begin
          n_fail++;
          $display("FAIL result: got pc=%h inst=%h exc=%b, required pc=%h inst=%h exc=%b",
                   bus.pc_o, bus.inst_o, bus.exc_o, e.pc, e.inst, e.exc);
        end
      end
    end
  end

  initial begin
    int base;
    rst               = 1'b1;
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    tick(3);

    // Reset state
    check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_inst", bus.inst_o, 32'h0000_0013);
    check("rst_exc", 32'(bus.exc_o), 32'd0);
    check("rst_cyc", 32'(bus.icyc_o), 32'd0);

    // Sequential fetch, then a 5-cycle downstream stall on pc 0x4
    exp_q.push_back('{pc: 32'h0, inst: 32'h5A5A_0000, exc: 2'b00});
    exp_q.push_back('{pc: 32'h4, inst: 32'h5A5A_0004, exc: 2'b00});
    exp_q.push_back('{pc: 32'h8, inst: 32'h5A5A_0008, exc: 2'b00});
    rst = 1'b0;
    check("idle_cycle_cyc", 32'(bus.icyc_o), 32'd0);
    wait_xfers(1, "first");
    bus.inst_ready_i = 1'b0;
    base = 0;
    while (!bus.inst_valid_o && base < BUDGET) begin
      tick(1);
      base++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out", {bus.inst_valid_o, bus.icyc_o, bus.exc_o, bus.pc_o[3:0], bus.inst_o[23:0]},
            {1'b1, 1'b0, 2'b00, 4'h4, 24'h5A_0004});
      tick(1);
    end
    bus.inst_ready_i = 1'b1;
    wait_xfers(3, "seq");
    check_log(0, 32'h0, "req0");
    check_log(1, 32'h4, "req1");
    check_log(2, 32'h8, "req_after_stall");

    // Slow ack with a redirect in the 2nd wait cycle: stale 0xC word is dropped
    latency = 3;
    exp_q.push_back('{pc: 32'h100, inst: 32'h5A5A_0100, exc: 2'b00});
    tick(1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    tick(1);
    bus.redirect_i    = 1'b0;
    wait_xfers(4, "redirect_100");
    check_log(3, 32'hC, "req_killed");
    check_log(4, 32'h100, "req_after_kill");

    // Simultaneous err+ack at 0x20 halts fetching until a redirect
    latency  = 0;
    err_addr = 32'h20;
    exp_q.push_back('{pc: 32'h20, inst: 32'h0000_0013, exc: 2'b01});
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h20;
    tick(1);
    bus.redirect_i    = 1'b0;
    wait_xfers(5, "bus_err");
    base = req_log.size();
    tick(4);
    check("halt_no_req", 32'(req_log.size()), 32'(base));
    check("halt_cyc", 32'(bus.icyc_o), 32'd0);
    check_log(base - 1, 32'h20, "req_err");
    err_addr = 32'h1;
    exp_q.push_back('{pc: 32'h40, inst: 32'h5A5A_0040, exc: 2'b00});
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    tick(1);
    bus.redirect_i    = 1'b0;
    wait_xfers(6, "resume_40");
    check_log(base, 32'h40, "req_resume");

    // Misaligned redirect: no bus cycle, exception result, then halt
    exp_q.push_back('{pc: 32'h102, inst: 32'h0000_0013, exc: 2'b10});
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h102;
    tick(1);
    bus.redirect_i    = 1'b0;
    base = req_log.size();
    wait_xfers(7, "misalign");
    tick(3);
    check("misalign_no_req", 32'(req_log.size()), 32'(base));
    check("misalign_cyc", 32'(bus.icyc_o), 32'd0);

    // PC wrap from the top of the address space
    latency = 3;
    exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'hA5A5_FFFC, exc: 2'b00});
    exp_q.push_back('{pc: 32'h0, inst: 32'h5A5A_0000, exc: 2'b00});
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick(1);
    bus.redirect_i    = 1'b0;
    wait_xfers(9, "wrap");
    check_log(base, 32'hFFFF_FFFC, "req_top");
    check_log(base + 1, 32'h0, "req_wrap");

    // Reset during an open bus cycle; a late ack must not produce a result
    check("pre_rst_cyc", 32'(bus.icyc_o), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_drops_cyc", 32'(bus.icyc_o), 32'd0);
    rst      = 1'b0;
    late_ack = 1'b1;
    exp_q.push_back('{pc: 32'h0, inst: 32'h5A5A_0000, exc: 2'b00});
    base = req_log.size();
    tick(1);
    late_ack = 1'b0;
    check("late_ack_valid", 32'(bus.inst_valid_o), 32'd0);
    wait_xfers(10, "post_rst");
    check_log(base, 32'h0, "req_post_rst");

    rst = 1'b1;
    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
